// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one N-bit adder among REQ
// requesters. One addition is in flight at a time: IDLE grants and captures
// operands, CALC registers the sum, RESP holds the result until accepted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid[REQ]      requester i offers an operand pair
//   req_ready[REQ]      requester i's pair is taken this cycle (one-hot, IDLE only)
//   req_num1/2[REQ*N]   requester i's operands in bits [i*N +: N]
//   rsp_valid/ready     response handshake
//   rsp_sum[N]          (num1 + num2) mod 2^N
//   rsp_id[IDW]         requester that owns rsp_sum
//   busy                FSM is not in IDLE
module adder_arbiter #(
  parameter int unsigned N   = 5,
  parameter int unsigned REQ = 4,
  localparam int unsigned IDW = $clog2(REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ-1:0]   req_valid,
  output logic [REQ-1:0]   req_ready,
  input  logic [REQ*N-1:0] req_num1,
  input  logic [REQ*N-1:0] req_num2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_sum,
  output logic [IDW-1:0]   rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gid;
  logic [N-1:0]   op1, op2;
  logic [N-1:0]   sum_c;
  logic [IDW-1:0] grant_c;
  logic           grant_vld_c;
  logic           accept_c;
  logic           rsp_fire_c;
  logic [IDW-1:0] rr_next_c;

  // Shared adder on the registered operands; carry out is dropped.
  assign sum_c = op1 + op2;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    grant_c     = '0;
    grant_vld_c = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < REQ; k++) begin
      idx = (32'(rr_ptr) + k) % REQ;
      if (!grant_vld_c && req_valid[IDW'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_c     = IDW'(idx);
      end
    end
  end

  assign accept_c   = (state == IDLE) && grant_vld_c && !rst;
  assign rsp_fire_c = rsp_valid && rsp_ready;
  assign rr_next_c  = (gid == IDW'(REQ - 1)) ? '0 : gid + IDW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and grant decode; req_ready is masked during reset.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          req_ready[grant_c] = 1'b1;
          state_next         = CALC;
        end
      end
      CALC: state_next = RESP;
      RESP: if (rsp_fire_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, result registers, pointer and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1       <= '0;
      op2       <= '0;
      gid       <= '0;
      rr_ptr    <= '0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (accept_c) begin
        op1 <= req_num1[32'(grant_c)*N +: N];
        op2 <= req_num2[32'(grant_c)*N +: N];
        gid <= grant_c;
      end
      if (state == CALC) begin
        rsp_sum   <= sum_c;
        rsp_id    <= gid;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_fire_c) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= rr_next_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (N=5, REQ=4).
module tb_adder_arbiter;

  localparam int unsigned N   = 5;
  localparam int unsigned REQ = 4;
  localparam int unsigned IDW = 2;

  logic             clk;
  logic             rst;
  logic [REQ-1:0]   req_valid;
  logic [REQ-1:0]   req_ready;
  logic [REQ*N-1:0] req_num1;
  logic [REQ*N-1:0] req_num2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_sum;
  logic [IDW-1:0]   rsp_id;
  logic             busy;

  int tests;
  int fails;

  adder_arbiter #(.N(N), .REQ(REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_num1  (req_num1),
    .req_num2  (req_num2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    req_num1[id*N +: N] = a;
    req_num2[id*N +: N] = b;
  endtask

  // Drive one request from an idle arbiter with rsp_ready high; return what was seen.
  task automatic do_txn(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [REQ-1:0] rdy, output logic vld,
                        output logic [N-1:0] sum, output logic [IDW-1:0] rid);
    set_ops(id, a, b);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b1;
    #1;
    rdy = req_ready;
    tick();
    req_valid = '0;
    tick();
    vld = rsp_valid;
    sum = rsp_sum;
    rid = rsp_id;
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_num1  = '0;
    req_num2  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests++; if (rsp_sum !== 5'd0) begin fails++; $display("FAIL reset_rsp_sum got=%0d exp=0", rsp_sum); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [REQ-1:0] rdy; logic vld; logic [N-1:0] s; logic [IDW-1:0] id;
    do_txn(1, 5'd3, 5'd4, rdy, vld, s, id);
    tests++; if (rdy !== 4'b0010) begin fails++; $display("FAIL single_ready got=%b exp=0010", rdy); end
    tests++; if (vld !== 1'b1) begin fails++; $display("FAIL single_rsp_valid got=%b exp=1", vld); end
    tests++; if (s !== 5'd7) begin fails++; $display("FAIL single_sum got=%0d exp=7", s); end
    tests++; if (id !== 2'd1) begin fails++; $display("FAIL single_id got=%0d exp=1", id); end
    tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL single_idle busy=%b rsp_valid=%b exp=0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_wrap();
    logic [REQ-1:0] rdy; logic vld; logic [N-1:0] s; logic [IDW-1:0] id;
    do_txn(3, 5'd25, 5'd10, rdy, vld, s, id);
    tests++; if (s !== 5'd3 || id !== 2'd3) begin fails++; $display("FAIL wrap_25_10 sum=%0d id=%0d exp=3/3", s, id); end
    do_txn(0, 5'd31, 5'd31, rdy, vld, s, id);
    tests++; if (s !== 5'd30 || id !== 2'd0) begin fails++; $display("FAIL wrap_31_31 sum=%0d id=%0d exp=30/0", s, id); end
  endtask

  // rr_ptr is 1 after the wrap test; reset to start the sequence at 0.
  task automatic test_round_robin();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    logic [REQ-1:0] exp_rdy;
    rst = 1'b1; #2; rst = 1'b0; tick();
    for (int i = 0; i < REQ; i++) set_ops(i, N'(i), N'(i));
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) begin
      exp_rdy = '0;
      exp_rdy[exp_id[t]] = 1'b1;
      tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_grant%0d got=%b exp=%b", t, req_ready, exp_rdy); end
      tick();
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rr_calc_ready%0d got=%b exp=0000", t, req_ready); end
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id[t]) || rsp_sum !== N'(2 * exp_id[t])) begin
        fails++; $display("FAIL rr_rsp%0d valid=%b id=%0d sum=%0d exp=1/%0d/%0d", t, rsp_valid, rsp_id, rsp_sum, exp_id[t], 2 * exp_id[t]);
      end
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  // rr_ptr is 1 here (last grant was 0).
  task automatic test_backpressure();
    logic ok;
    set_ops(0, 5'd5, 5'd6);
    set_ops(2, 5'd7, 5'd8);
    set_ops(3, 5'd1, 5'd2);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b1100;
    tick();
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1'b1 || rsp_sum !== 5'd11 || rsp_id !== 2'd0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        ok = 1'b0;
        $display("FAIL bp_hold cycle%0d valid=%b sum=%0d id=%0d ready=%b busy=%b exp=1/11/0/0000/1",
                 c, rsp_valid, rsp_sum, rsp_id, req_ready, busy);
      end
      tick();
    end
    tests++; if (!ok) fails++;
    rsp_ready = 1'b1;
    tick();
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_next_grant got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tests++; if (rsp_sum !== 5'd15 || rsp_id !== 2'd2) begin fails++; $display("FAIL bp_req2_rsp sum=%0d id=%0d exp=15/2", rsp_sum, rsp_id); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [REQ-1:0] rdy; logic vld; logic [N-1:0] s; logic [IDW-1:0] id;
    logic seen;
    set_ops(0, 5'd9, 5'd9);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_in_calc busy=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0 || rsp_sum !== 5'd0 || rsp_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL rmid_outputs valid=%b sum=%0d id=%0d busy=%b ready=%b exp=all0", rsp_valid, rsp_sum, rsp_id, busy, req_ready);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    tests++; if (seen) begin fails++; $display("FAIL rmid_no_response got=response exp=none"); end
    do_txn(0, 5'd1, 5'd1, rdy, vld, s, id);
    tests++; if (vld !== 1'b1 || s !== 5'd2 || id !== 2'd0) begin
      fails++; $display("FAIL rmid_fresh valid=%b sum=%0d id=%0d exp=1/2/0", vld, s, id);
    end
  endtask

  task automatic test_withdrawn();
    logic bad;
    bad = 1'b0;
    set_ops(1, 5'd3, 5'd3);
    set_ops(2, 5'd4, 5'd4);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL wd_grant1 got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0100;
    #1;
    if (req_ready[2] !== 1'b0) bad = 1'b1;
    tick();
    if (req_ready[2] !== 1'b0) bad = 1'b1;
    req_valid = '0;
    tests++; if (rsp_sum !== 5'd6 || rsp_id !== 2'd1) begin fails++; $display("FAIL wd_rsp sum=%0d id=%0d exp=6/1", rsp_sum, rsp_id); end
    rsp_ready = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      if (req_ready[2] !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    tests++; if (bad) begin fails++; $display("FAIL wd_never_granted got=granted_or_busy exp=idle"); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_withdrawn();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
